// File: rtl/irq_pc_trigger_ctrl.sv
// irq_pc_trigger_ctrl
// Multi-channel external-interrupt stimulus source for a CPU test harness.
// Each channel watches the macroscopic PC for entry into a programmable
// address window and raises a pending bit. The pending bits are OR'd into a
// single interrupt line. The CPU clears one pending bit, the lowest-index one,
// by storing to ACK_ADDR.
// Optional feature: define IRQ_HOLDOFF_EN to suppress all fires for HOLDOFF
// cycles after every acknowledge.
module irq_pc_trigger_ctrl #(
   parameter int          N_CH     = 4,
   parameter int          CH_W     = 2,
   parameter int          CNT_W    = 4,
   parameter logic [31:0] ACK_ADDR = 32'h7F20,
   parameter int          HOLDOFF  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      macroscopic_pc,
   input  logic [31:0]      m_data_addr,
   input  logic [3:0]       m_data_byteen,
   input  logic             cfg_we,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [31:0]      cfg_lo,
   input  logic [31:0]      cfg_hi,
   input  logic [CNT_W-1:0] cfg_count,
   output logic             interrupt,
   output logic [N_CH-1:0]  irq_pending,
   output logic [CH_W-1:0]  irq_id
);

   localparam int HO_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

   // Per-channel configuration and match history
   logic [31:0]      lo_reg    [N_CH];
   logic [31:0]      hi_reg    [N_CH];
   logic [CNT_W-1:0] count_reg [N_CH];
   logic [N_CH-1:0]  hist_reg;

   // Output registers
   logic [N_CH-1:0]  pending_reg;
   logic [N_CH-1:0]  pending_next;
   logic             interrupt_reg;
   logic [CH_W-1:0]  irq_id_reg;
   logic [CH_W-1:0]  irq_id_next;

   // Decoded per-cycle terms
   logic [31:0]      pc_w;
   logic [31:0]      ack_w;
   logic             ack_store;
   logic             ack_valid;
   logic [N_CH-1:0]  ack_mask;
   logic [N_CH-1:0]  in_win;
   logic [N_CH-1:0]  cfg_hit;
   logic [N_CH-1:0]  fire;
   logic [N_CH-1:0]  hist_next;
   logic [N_CH-1:0]  pending_after_ack;
   logic             fire_block;

   assign pc_w      = macroscopic_pc & ~32'd3;
   assign ack_w     = m_data_addr & ~32'd3;
   assign ack_store = (|m_data_byteen) && (ack_w == ACK_ADDR);
   // An ack with nothing pending has no effect at all
   assign ack_valid = ack_store && (|pending_reg);

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         // Unsigned inclusive window; lo > hi can never match
         assign in_win[gi]   = (lo_reg[gi] <= pc_w) && (pc_w <= hi_reg[gi]);
         // Indices >= N_CH never match any channel, so such writes are ignored
         assign cfg_hit[gi]  = cfg_we && (cfg_ch == CH_W'(gi));
         assign ack_mask[gi] = ack_valid && (irq_id_reg == CH_W'(gi));
         // Pending is tested after the ack so ack+fire on one channel re-arms it
         assign fire[gi]     = in_win[gi] && !hist_reg[gi]
                               && (count_reg[gi] != '0)
                               && !pending_after_ack[gi]
                               && !cfg_hit[gi] && !fire_block;
         // A config write forgets history so a PC already inside fires next cycle
         assign hist_next[gi] = cfg_hit[gi] ? 1'b0 : in_win[gi];
      end
   endgenerate

   assign pending_after_ack = pending_reg & ~ack_mask;
   assign pending_next      = pending_after_ack | fire;

`ifdef IRQ_HOLDOFF_EN
   logic [HO_W-1:0] holdoff_reg;

   assign fire_block = (holdoff_reg != '0);

   // Holdoff counter: reloaded by each ack, counts down to zero
   always_ff @(posedge clk) begin
      if (!reset) begin
         holdoff_reg <= '0;
      end else if (ack_valid) begin
         holdoff_reg <= HO_W'(HOLDOFF);
      end else if (holdoff_reg != '0) begin
         holdoff_reg <= holdoff_reg - HO_W'(1);
      end
   end
`else
   assign fire_block = 1'b0;
`endif

   // Lowest-index pending channel of the next state; 0 when none pending
   always_comb begin
      irq_id_next = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (pending_next[i]) begin
            irq_id_next = CH_W'(i);
         end
      end
   end

   // Channel configuration, fire budget and match history
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < N_CH; i++) begin
            lo_reg[i]    <= '0;
            hi_reg[i]    <= '0;
            count_reg[i] <= '0;
         end
         hist_reg <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (cfg_hit[i]) begin
               lo_reg[i]    <= cfg_lo & ~32'd3;
               hi_reg[i]    <= cfg_hi & ~32'd3;
               count_reg[i] <= cfg_count;
            end else if (fire[i]) begin
               count_reg[i] <= count_reg[i] - CNT_W'(1);
            end
         end
         hist_reg <= hist_next;
      end
   end

   // Pending bits and the registered outputs derived from them
   always_ff @(posedge clk) begin
      if (!reset) begin
         pending_reg   <= '0;
         interrupt_reg <= 1'b0;
         irq_id_reg    <= '0;
      end else begin
         pending_reg   <= pending_next;
         interrupt_reg <= |pending_next;
         irq_id_reg    <= irq_id_next;
      end
   end

   assign interrupt   = interrupt_reg;
   assign irq_pending = pending_reg;
   assign irq_id      = irq_id_reg;

endmodule

// File: tb/tb_irq_pc_trigger_ctrl.sv
// Testbench for irq_pc_trigger_ctrl: directed stimulus, expected outputs
// queued with each driven cycle and popped for comparison after the edge.
module tb_irq_pc_trigger_ctrl;

   localparam int N_CH  = 4;
   localparam int CH_W  = 2;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [31:0]      macroscopic_pc = 32'h1000;
   logic [31:0]      m_data_addr = 32'h0;
   logic [3:0]       m_data_byteen = 4'h0;
   logic             cfg_we = 1'b0;
   logic [CH_W-1:0]  cfg_ch = '0;
   logic [31:0]      cfg_lo = 32'h0;
   logic [31:0]      cfg_hi = 32'h0;
   logic [CNT_W-1:0] cfg_count = '0;
   logic             interrupt;
   logic [N_CH-1:0]  irq_pending;
   logic [CH_W-1:0]  irq_id;

   typedef struct packed {
      logic            intr;
      logic [N_CH-1:0] pend;
      logic [CH_W-1:0] id;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;
   int   n_cyc  = 0;

   irq_pc_trigger_ctrl #(
      .N_CH(N_CH), .CH_W(CH_W), .CNT_W(CNT_W),
      .ACK_ADDR(32'h7F20), .HOLDOFF(8)
   ) dut (
      .clk(clk), .reset(reset),
      .macroscopic_pc(macroscopic_pc),
      .m_data_addr(m_data_addr), .m_data_byteen(m_data_byteen),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
      .cfg_count(cfg_count),
      .interrupt(interrupt), .irq_pending(irq_pending), .irq_id(irq_id)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, queue the expectation, compare after the edge
   task automatic step(input string tag, input logic [31:0] pc, input logic ack,
                       input logic [N_CH-1:0] e_pend, input logic [CH_W-1:0] e_id);
      exp_t e;
      macroscopic_pc = pc;
      m_data_addr    = ack ? 32'h7F22 : 32'h0000_7F30;
      m_data_byteen  = ack ? 4'b0001 : 4'b0000;
      e.intr = |e_pend;
      e.pend = e_pend;
      e.id   = e_id;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      n_cyc++;
      e = exp_q.pop_front();
      $display("[%0d] %s pc=%08h ack=%0b -> int=%0b pend=%b id=%0d", n_cyc, tag, pc, ack,
               interrupt, irq_pending, irq_id);
      check_val({tag, ".int"},  32'(interrupt),   32'(e.intr));
      check_val({tag, ".pend"}, 32'(irq_pending), 32'(e.pend));
      check_val({tag, ".id"},   32'(irq_id),      32'(e.id));
      cfg_we        = 1'b0;
      m_data_byteen = 4'b0000;
   endtask

   task automatic cfg(input string tag, input logic [CH_W-1:0] ch, input logic [31:0] lo,
                      input logic [31:0] hi, input logic [CNT_W-1:0] cnt, input logic [31:0] pc,
                      input logic [N_CH-1:0] e_pend, input logic [CH_W-1:0] e_id);
      cfg_we    = 1'b1;
      cfg_ch    = ch;
      cfg_lo    = lo;
      cfg_hi    = hi;
      cfg_count = cnt;
      step(tag, pc, 1'b0, e_pend, e_id);
   endtask

   initial begin
      #1;
      // Reset state
      reset = 1'b0;
      step("rst0", 32'h1000, 1'b0, 4'b0000, 2'd0);
      step("rst1", 32'h1000, 1'b0, 4'b0000, 2'd0);
      reset = 1'b1;

      // Single-address window, budget 1
      cfg ("c0",      2'd0, 32'h304c, 32'h304c, 4'd1, 32'h3048, 4'b0000, 2'd0);
      step("pre0",    32'h3048, 1'b0, 4'b0000, 2'd0);
      step("fire0",   32'h304c, 1'b0, 4'b0001, 2'd0);
      step("ack0",    32'h304d, 1'b1, 4'b0000, 2'd0);
      step("out0",    32'h3048, 1'b0, 4'b0000, 2'd0);
      step("spent0",  32'h304c, 1'b0, 4'b0000, 2'd0);

      // Two-word window, stall inside fires once; ack+re-entry same cycle
      cfg ("c1",      2'd1, 32'h304c, 32'h3050, 4'd3, 32'h3000, 4'b0000, 2'd0);
      step("fire1a",  32'h304c, 1'b0, 4'b0010, 2'd1);
      step("iter1",   32'h3050, 1'b0, 4'b0010, 2'd1);
      step("stall1",  32'h3050, 1'b0, 4'b0010, 2'd1);
      step("leave1",  32'h3100, 1'b0, 4'b0010, 2'd1);
      step("ack1",    32'h3100, 1'b1, 4'b0000, 2'd0);
      step("fire1b",  32'h304c, 1'b0, 4'b0010, 2'd1);
      step("leave1b", 32'h3100, 1'b0, 4'b0010, 2'd1);
      step("ackfire", 32'h304c, 1'b1, 4'b0010, 2'd1);
      step("ack1c",   32'h3100, 1'b1, 4'b0000, 2'd0);
      step("spent1",  32'h304c, 1'b0, 4'b0000, 2'd0);

      // Simultaneous fires, priority acknowledge
      cfg ("c0b",     2'd0, 32'h2000, 32'h2000, 4'd2, 32'h1000, 4'b0000, 2'd0);
      cfg ("c2",      2'd2, 32'h1ff0, 32'h2010, 4'd2, 32'h1000, 4'b0000, 2'd0);
      step("fire02",  32'h2000, 1'b0, 4'b0101, 2'd0);
      step("ackp0",   32'h2000, 1'b1, 4'b0100, 2'd2);
      step("ackp2",   32'h2000, 1'b1, 4'b0000, 2'd0);
      step("ackidle", 32'h2000, 1'b1, 4'b0000, 2'd0);

      // Config with PC already inside the new window fires next cycle
      cfg ("c3",      2'd3, 32'h2000, 32'h2000, 4'd1, 32'h2000, 4'b0000, 2'd0);
      step("fire3",   32'h2000, 1'b0, 4'b1000, 2'd3);
      step("ack3",    32'h1000, 1'b1, 4'b0000, 2'd0);

      // Empty window (lo > hi) never fires
      cfg ("c2e",     2'd2, 32'h3000, 32'h2000, 4'd5, 32'h1000, 4'b0000, 2'd0);
      step("empty2",  32'h2800, 1'b0, 4'b0000, 2'd0);

      // Config write beats a same-cycle fire on the same channel
      cfg ("c0win",   2'd0, 32'h2000, 32'h2000, 4'd1, 32'h2000, 4'b0000, 2'd0);
      step("fire0c",  32'h2000, 1'b0, 4'b0001, 2'd0);

      // Mid-operation reset clears pending and budgets
      reset = 1'b0;
      step("rstmid",  32'h2000, 1'b0, 4'b0000, 2'd0);
      reset = 1'b1;
      step("postr0",  32'h1000, 1'b0, 4'b0000, 2'd0);
      step("postr1",  32'h2000, 1'b0, 4'b0000, 2'd0);

      // Re-entry after an ack
      cfg ("c1h",     2'd1, 32'h4000, 32'h4000, 4'd3, 32'h1000, 4'b0000, 2'd0);
      step("fireh",   32'h4000, 1'b0, 4'b0010, 2'd1);
      step("ackh",    32'h1000, 1'b1, 4'b0000, 2'd0);
`ifdef IRQ_HOLDOFF_EN
      step("ho1",     32'h1000, 1'b0, 4'b0000, 2'd0);
      step("ho2",     32'h1000, 1'b0, 4'b0000, 2'd0);
      step("hoblk",   32'h4000, 1'b0, 4'b0000, 2'd0);
      for (int i = 0; i < 5; i++) begin
         step("howait", 32'h1000, 1'b0, 4'b0000, 2'd0);
      end
      step("hofire",  32'h4000, 1'b0, 4'b0010, 2'd1);
`else
      step("refire",  32'h4000, 1'b0, 4'b0010, 2'd1);
`endif
      step("ackend",  32'h1000, 1'b1, 4'b0000, 2'd0);

      if (exp_q.size() != 0) begin
         check_val("sb_drain", 32'(exp_q.size()), 32'd0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
